// File: rtl/icache_refill_wen_seq.sv
// icache refill write-enable sequencer: one registered one-hot bank enable
// per accepted refill beat (critical-word-first wrap), plus all-bank invalidate.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_vld/req_rdy   request handshake (ready only in IDLE)
//   req_inv           1 = invalidate all banks, 0 = refill
//   req_start_idx     first bank of the refill
//   req_len           beat count, 0 encodes WIDTH
//   req_way           target way
//   beat_vld/beat_rdy refill data beat handshake (ready in BUSY, not flushing)
//   flush             abort a refill in progress
//   wr_en             bank write enable (one-hot, all-ones on invalidate)
//   wr_way_en         way write enable (one-hot, valid with wr_en)
//   done              pulses with the final wr_en of a request
module icache_refill_wen_seq #(
  parameter int WIDTH = 8,
  parameter int WAYS  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_vld,
  output logic                                   req_rdy,
  input  logic                                   req_inv,
  input  logic [$clog2(WIDTH)-1:0]               req_start_idx,
  input  logic [$clog2(WIDTH):0]                 req_len,
  input  logic [((WAYS>1)?$clog2(WAYS):1)-1:0]   req_way,
  input  logic                                   beat_vld,
  output logic                                   beat_rdy,
  input  logic                                   flush,
  output logic [WIDTH-1:0]                       wr_en,
  output logic [WAYS-1:0]                        wr_way_en,
  output logic                                   done
);

  localparam int IW = $clog2(WIDTH);
  localparam int LW = IW + 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [LW-1:0]  rem, rem_n;
  logic [WW-1:0]  way, way_n;
  logic [WIDTH-1:0] wr_en_n;
  logic [WAYS-1:0]  way_en_n;
  logic           done_n;

  logic req_acc;
  logic beat_acc;
  logic flush_busy;

  assign req_rdy    = (state == IDLE);
  assign beat_rdy   = (state == BUSY) && !flush;
  assign req_acc    = req_vld && req_rdy;
  assign beat_acc   = beat_vld && beat_rdy;
  assign flush_busy = (state == BUSY) && flush;

  // The four events are mutually exclusive: requests are only taken in
  // IDLE, and beats are only taken in BUSY when not flushing.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    rem_n    = rem;
    way_n    = way;
    wr_en_n  = '0;
    way_en_n = '0;
    done_n   = 1'b0;
    unique case (1'b1)
      req_acc && req_inv: begin
        wr_en_n  = '1;
        way_en_n = WAYS'(1) << req_way;
        done_n   = 1'b1;
      end
      req_acc && !req_inv: begin
        state_n = BUSY;
        idx_n   = req_start_idx;
        rem_n   = (req_len == '0) ? LW'(WIDTH) : req_len;
        way_n   = req_way;
      end
      flush_busy: begin
        state_n = IDLE;
      end
      beat_acc: begin
        wr_en_n  = WIDTH'(1) << idx;
        way_en_n = WAYS'(1) << way;
        // explicit wrap keeps non-power-of-two bank counts correct
        idx_n    = (idx == IW'(WIDTH - 1)) ? '0 : idx + IW'(1);
        rem_n    = rem - LW'(1);
        if (rem == LW'(1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      rem       <= '0;
      way       <= '0;
      wr_en     <= '0;
      wr_way_en <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      rem       <= rem_n;
      way       <= way_n;
      wr_en     <= wr_en_n;
      wr_way_en <= way_en_n;
      done      <= done_n;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && req_acc && !req_inv)
      assert (32'(req_start_idx) < WIDTH)
        else $error("req_start_idx out of range");
    if (rst_n && req_acc)
      assert (32'(req_way) < WAYS)
        else $error("req_way out of range");
    if (rst_n)
      assert ($onehot0(wr_en) || (&wr_en))
        else $error("wr_en not one-hot");
    if (rst_n)
      assert ($onehot0(wr_way_en))
        else $error("wr_way_en not one-hot");
  end
`endif

endmodule
